sat_ammo_counter: RTL and testbench

Saturating, loadable up/down counter for the spaceship weapons subsystem. It tracks the ammunition count between a programmable ceiling and zero, and decrements by a configurable fire rate. The block is built entirely from the shared primitive cells `DFF`, `Mux2` and `Mux4`, and sits between the weapons-mode logic and the ammo display/status path.

---
 rtl/weapons_pkg.sv | 14 +
 rtl/sat_ammo_cells.sv | 38 +++
 rtl/sat_ammo_counter_sat_step.sv | 21 ++
 rtl/sat_ammo_counter.sv | 92 +++++++++
 tb/tb_sat_ammo_counter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/weapons_pkg.sv
// Shared weapons-subsystem constants: ammo width and the one-hot mux select codes.
package weapons_pkg;

    localparam int AMMO_W = 9;

    localparam logic [3:0] SEL4_HOLD = 4'b1000;
    localparam logic [3:0] SEL4_LOAD = 4'b0100;
    localparam logic [3:0] SEL4_STEP = 4'b0010;
    localparam logic [3:0] SEL4_RST  = 4'b0001;

    localparam logic [1:0] SEL2_LOAD = 2'b10;
    localparam logic [1:0] SEL2_HOLD = 2'b01;

endpackage

// File: rtl/sat_ammo_cells.sv
// Shared primitive cells: plain register and AND-OR one-hot multiplexers.
// Non-one-hot selects OR the selected inputs together; an all-zero select yields 0.
module DFF #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        q <= d;
    end
endmodule

module Mux2 #(
    parameter int N = 1
) (
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [1:0]   s,
    output logic [N-1:0] y
);
    assign y = ({N{s[1]}} & a0) | ({N{s[0]}} & a1);
endmodule

module Mux4 #(
    parameter int N = 1
) (
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [3:0]   s,
    output logic [N-1:0] y
);
    assign y = ({N{s[3]}} & a0) | ({N{s[2]}} & a1)
             | ({N{s[1]}} & a2) | ({N{s[0]}} & a3);
endmodule

// File: rtl/sat_ammo_counter_sat_step.sv
// Saturating step value: down by rate floors at zero, up by one clamps to the ceiling.
module sat_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] max,
    input  logic [N-1:0] rate,
    input  logic         up,
    input  logic         down,
    output logic [N-1:0] step_val
);
    always_comb begin
        step_val = count;
        if (down) begin
            step_val = (count >= rate) ? (count - rate) : '0;
        end else if (up) begin
            // An over-ceiling count (loaded above max) is pulled back to max.
            step_val = (count < max) ? (count + N'(1)) : max;
        end
    end
endmodule

// File: rtl/sat_ammo_counter.sv
// Saturating loadable ammo counter with programmable ceiling.
// Optional fire_err output enabled by defining SAT_AMMO_FIRE_ERR_EN.
module sat_ammo_counter
    import weapons_pkg::*;
#(
    parameter int N = AMMO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up,
    input  logic         down,
    input  logic         load,
    input  logic [1:0]   load_max,
    input  logic [N-1:0] in,
    input  logic [N-1:0] rate,
    output logic [N-1:0] out,
    output logic [N-1:0] max_out
`ifdef SAT_AMMO_FIRE_ERR_EN
    ,
    output logic         fire_err
`endif
);

    logic [3:0]   sel4;
    logic [1:0]   sel2;
    logic [N-1:0] step_val;
    logic [N-1:0] count_d;
    logic [N-1:0] ceil_mux;
    logic [N-1:0] ceil_d;
    logic [N-1:0] zero;

    assign zero = '0;

    // rst > load > step > hold; exactly one select is ever active.
    always_comb begin
        sel4 = SEL4_HOLD;
        if (rst) begin
            sel4 = SEL4_RST;
        end else if (load) begin
            sel4 = SEL4_LOAD;
        end else if (up || down) begin
            sel4 = SEL4_STEP;
        end
    end

    // Only the exact load code loads; 00 and 11 both hold.
    assign sel2 = (load_max == SEL2_LOAD) ? SEL2_LOAD : SEL2_HOLD;

    sat_step #(.N(N)) u_sat_step (
        .count    (out),
        .max      (max_out),
        .rate     (rate),
        .up       (up),
        .down     (down),
        .step_val (step_val)
    );

    Mux4 #(.N(N)) u_count_mux (
        .a0 (out),
        .a1 (in),
        .a2 (step_val),
        .a3 (zero),
        .s  (sel4),
        .y  (count_d)
    );

    DFF #(.N(N)) u_count_reg (
        .clk (clk),
        .d   (count_d),
        .q   (out)
    );

    Mux2 #(.N(N)) u_ceil_mux (
        .a0 (in),
        .a1 (max_out),
        .s  (sel2),
        .y  (ceil_mux)
    );

    assign ceil_d = ceil_mux | {N{rst}};

    DFF #(.N(N)) u_ceil_reg (
        .clk (clk),
        .d   (ceil_d),
        .q   (max_out)
    );

`ifdef SAT_AMMO_FIRE_ERR_EN
    assign fire_err = ~rst & ~load & down & (out < rate);
`endif

endmodule

// File: tb/tb_sat_ammo_counter.sv
// Directed table-driven bench for sat_ammo_counter (fire_err checked when SAT_AMMO_FIRE_ERR_EN is defined).
module tb_sat_ammo_counter;

    localparam int N = 9;

    logic         clk;
    logic         rst;
    logic         up;
    logic         down;
    logic         load;
    logic [1:0]   load_max;
    logic [N-1:0] in;
    logic [N-1:0] rate;
    logic [N-1:0] out;
    logic [N-1:0] max_out;
    logic         fire_err_s;

    int checks = 0;
    int errors = 0;

    sat_ammo_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .load     (load),
        .load_max (load_max),
        .in       (in),
        .rate     (rate),
        .out      (out),
        .max_out  (max_out)
`ifdef SAT_AMMO_FIRE_ERR_EN
        ,
        .fire_err (fire_err_s)
`endif
    );

`ifndef SAT_AMMO_FIRE_ERR_EN
    assign fire_err_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v_rst;
        logic         v_up;
        logic         v_down;
        logic         v_load;
        logic [1:0]   v_lmax;
        logic [N-1:0] v_in;
        logic [N-1:0] v_rate;
        logic         e_fire;
        logic [N-1:0] e_out;
        logic [N-1:0] e_max;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic u, logic d, logic l, logic [1:0] lm,
                                int i, int rt, logic ef, int eo, int em);
        vec_t v;
        v.v_rst = r; v.v_up = u; v.v_down = d; v.v_load = l; v.v_lmax = lm;
        v.v_in = N'(i); v.v_rate = N'(rt);
        v.e_fire = ef; v.e_out = N'(eo); v.e_max = N'(em);
        return v;
    endfunction

    task automatic apply(input logic r, input logic u, input logic d, input logic l,
                         input logic [1:0] lm, input logic [N-1:0] i, input logic [N-1:0] rt);
        @(negedge clk);
        rst = r; up = u; down = d; load = l; load_max = lm; in = i; rate = rt;
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0;
        load_max = 2'b00; in = '0; rate = '0;

        //                r  u  d  l  lmax   in  rate fire out  max
        vecs.push_back(mk(1, 0, 0, 0, 2'b00,   0,   0, 0,   0, 511));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00,   0,   0, 0,   0, 511));
        vecs.push_back(mk(0, 0, 0, 0, 2'b10, 120,   0, 0,   0, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b00, 118,   0, 0, 118, 120));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0, 119, 120));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0, 120, 120));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0, 120, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b00,  12,   0, 0,  12, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,   5, 0,   7, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,   5, 0,   2, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,   5, 1,   0, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b00,  50,   0, 0,  50, 120));
        vecs.push_back(mk(0, 1, 1, 0, 2'b00,   0,   3, 0,  47, 120));
        vecs.push_back(mk(0, 0, 1, 1, 2'b00,   9,   3, 0,   9, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,   0, 0,   9, 120));
        vecs.push_back(mk(0, 0, 0, 0, 2'b11,   5,   0, 0,   9, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b00, 200,   0, 0, 200, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,  10, 0, 190, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,  10, 0, 180, 120));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,  10, 0, 170, 120));
        vecs.push_back(mk(1, 0, 1, 0, 2'b00,   0, 255, 0,   0, 511));
        vecs.push_back(mk(0, 0, 0, 0, 2'b10, 120,   0, 0,   0, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b00, 300,   0, 0, 300, 120));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0, 120, 120));
        vecs.push_back(mk(0, 0, 0, 1, 2'b10,   7,   0, 0,   7,   7));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0,   7,   7));
        vecs.push_back(mk(0, 0, 1, 0, 2'b00,   0,   7, 0,   0,   7));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0,   1,   7));
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   3,   0, 0,   1,   7));
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   0,   0, 0,   2,   7));

        foreach (vecs[k]) begin
            apply(vecs[k].v_rst, vecs[k].v_up, vecs[k].v_down, vecs[k].v_load,
                  vecs[k].v_lmax, vecs[k].v_in, vecs[k].v_rate);
`ifdef SAT_AMMO_FIRE_ERR_EN
            check("fire_err", k, N'(fire_err_s), N'(vecs[k].e_fire));
`endif
            @(posedge clk);
            #1;
            check("out", k, out, vecs[k].e_out);
            check("max_out", k, max_out, vecs[k].e_max);
        end

        // Reset beats a simultaneous load and ceiling load.
        apply(1, 1, 0, 1, 2'b10, 33, 0);
        @(posedge clk);
        #1;
        check("rst_prio_out", 0, out, 0);
        check("rst_prio_max", 0, max_out, 511);

        // Count holds across idle cycles, even with in/rate wiggling.
        apply(0, 0, 0, 1, 2'b00, 77, 0);
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            apply(0, 0, 0, 0, 2'b00, N'(c * 13), N'(c + 1));
            @(posedge clk);
            #1;
            check("hold_out", c, out, 77);
            check("hold_max", c, max_out, 511);
        end

        // Up from just below the all-ones ceiling clamps at 511, no wrap.
        apply(0, 0, 0, 1, 2'b00, 510, 0);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            apply(0, 1, 0, 0, 2'b00, 0, 0);
            @(posedge clk);
            #1;
            check("top_clamp", c, out, 511);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
